// File: rtl/bcd_cascade_timer_pkg.sv
// Shared definitions for the BCD cascade timer: digit limit, FSM encoding
// and the per-digit sanitising helper.
package bcd_cascade_timer_pkg;

   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   // Force a nibble into the legal BCD range; anything above 9 reads as 9.
   function automatic logic [3:0] bcd_clamp_digit(input logic [3:0] digit);
      return (digit > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : digit;
   endfunction

   // True when a nibble is a legal BCD digit.
   function automatic logic bcd_digit_ok(input logic [3:0] digit);
      return digit <= BCD_DIGIT_MAX;
   endfunction

   // Packed BCD values order the same way as their plain binary encoding,
   // so a magnitude compare needs no per-digit work.
   function automatic logic bcd_greater(input logic [63:0] a, input logic [63:0] b);
      return a > b;
   endfunction

endpackage

// File: rtl/bcd_cascade_timer_digit.sv
// One BCD digit of the step chain: computes the stepped digit value and the
// carry (up) or borrow (down) handed to the next more significant digit.
module bcd_digit
   import bcd_cascade_timer_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       en,
   input  logic       dir,
   output logic [3:0] next_digit,
   output logic       carry
);

   // Increment or decrement this digit when the lower digits roll over.
   always_comb begin
      next_digit = digit;
      carry      = 1'b0;
      if (en) begin
         if (!dir) begin
            if (digit >= BCD_DIGIT_MAX) begin
               next_digit = 4'd0;
               carry      = 1'b1;
            end else begin
               next_digit = digit + 4'd1;
            end
         end else begin
            if (digit == 4'd0) begin
               next_digit = BCD_DIGIT_MAX;
               carry      = 1'b1;
            end else begin
               next_digit = digit - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_cascade_timer.sv
// Multi-digit BCD up/down counter with IDLE/RUN/PAUSE run control,
// modulus wrap at WRAP_VAL, sanitised preset load and lap capture.
module bcd_cascade_timer
   import bcd_cascade_timer_pkg::*;
#(
   parameter int                   NDIGITS  = 3,
   parameter logic [4*NDIGITS-1:0] WRAP_VAL = 12'h999,
   parameter bit                   AUTO_RUN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_en,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear,
   input  logic                 dir,
   input  logic                 load,
   input  logic [4*NDIGITS-1:0] load_val,
   input  logic                 lap,
   output logic [4*NDIGITS-1:0] count,
   output logic                 wrap_pulse,
   output logic                 running,
   output logic [4*NDIGITS-1:0] lap_val
);

   localparam int W = 4 * NDIGITS;
   localparam state_t RESET_STATE = AUTO_RUN ? ST_RUN : ST_IDLE;

   state_t         state, state_nxt;
   logic [W-1:0]   stepped;
   logic [W-1:0]   clamped;
   logic [W-1:0]   loaded;
   logic [W-1:0]   count_nxt;
   logic [NDIGITS:0] chain;
   logic           step;
   logic           wrap_hit;

   // Ripple chain: digit 0 always steps, each higher digit steps on the
   // carry/borrow of the one below. The final borrow out means count == 0.
   assign chain[0] = 1'b1;

   for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .digit      (count[4*g +: 4]),
         .en         (chain[g]),
         .dir        (dir),
         .next_digit (stepped[4*g +: 4]),
         .carry      (chain[g+1])
      );

      if (!bcd_digit_ok(WRAP_VAL[4*g +: 4])) begin : g_bad_wrap
         $error("bcd_cascade_timer: WRAP_VAL digit %0d is not a BCD digit", g);
      end
   end

   assign running  = (state == ST_RUN);
   assign step     = running && tick_en && !clear && !load;
   assign wrap_hit = step && (dir ? chain[NDIGITS] : (count == WRAP_VAL));

   // Run-control next state; clear dominates, stop beats a simultaneous start.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start && !stop) state_nxt = ST_RUN;
            ST_RUN:   if (stop)           state_nxt = ST_PAUSE;
            ST_PAUSE: if (start && !stop) state_nxt = ST_RUN;
            default:                      state_nxt = ST_IDLE;
         endcase
      end
   end

   // Preset sanitiser: clamp each nibble to 9, then clamp the value to WRAP_VAL.
   always_comb begin
      clamped = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         clamped[4*i +: 4] = bcd_clamp_digit(load_val[4*i +: 4]);
      end
      loaded = bcd_greater(64'(clamped), 64'(WRAP_VAL)) ? WRAP_VAL : clamped;
   end

   // Count update priority: clear, then load, then a qualified step.
   always_comb begin
      count_nxt = count;
      if (clear) begin
         count_nxt = '0;
      end else if (load) begin
         count_nxt = loaded;
      end else if (step) begin
         if (wrap_hit) begin
            count_nxt = dir ? WRAP_VAL : '0;
         end else begin
            count_nxt = stepped;
         end
      end
   end

   // State, count, wrap strobe and lap register; lap samples the pre-update count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RESET_STATE;
         count      <= '0;
         wrap_pulse <= 1'b0;
         lap_val    <= '0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         wrap_pulse <= wrap_hit;
         if (lap) begin
            lap_val <= count;
         end
      end
   end

endmodule

// File: tb/tb_bcd_cascade_timer.sv
// Bench for bcd_cascade_timer: three instances (default 3-digit, 3-digit with
// a 059 modulus, 4-digit) share one stimulus stream and are compared with a
// decimal-arithmetic reference model.
module tb_bcd_cascade_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, tick_en, start, stop, clear, dir, load, lap;
   logic [15:0] load_val;

   logic [11:0] c0, l0, cw, lw;
   logic [15:0] c4, l4;
   logic        w0, ww, w4, r0, rw, r4;

   int nvec = 0;
   int nerr = 0;

   // Reference model state: decimal count, lap and wrap flag per instance.
   int mc[3];
   int ml[3];
   bit mw[3];
   int mst;                       // 0 idle, 1 run, 2 pause
   int nd[3] = '{3, 3, 4};
   int mx[3] = '{999, 59, 9999};

   bcd_cascade_timer dut (
      .clk(clk), .reset(reset), .tick_en(tick_en), .start(start), .stop(stop),
      .clear(clear), .dir(dir), .load(load), .load_val(load_val[11:0]), .lap(lap),
      .count(c0), .wrap_pulse(w0), .running(r0), .lap_val(l0));

   bcd_cascade_timer #(.NDIGITS(3), .WRAP_VAL(12'h059), .AUTO_RUN(1'b1)) dut_w (
      .clk(clk), .reset(reset), .tick_en(tick_en), .start(start), .stop(stop),
      .clear(clear), .dir(dir), .load(load), .load_val(load_val[11:0]), .lap(lap),
      .count(cw), .wrap_pulse(ww), .running(rw), .lap_val(lw));

   bcd_cascade_timer #(.NDIGITS(4), .WRAP_VAL(16'h9999), .AUTO_RUN(1'b1)) dut4 (
      .clk(clk), .reset(reset), .tick_en(tick_en), .start(start), .stop(stop),
      .clear(clear), .dir(dir), .load(load), .load_val(load_val), .lap(lap),
      .count(c4), .wrap_pulse(w4), .running(r4), .lap_val(l4));

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int sanitize(input logic [15:0] raw, input int ndig, input int mxv);
      int v, p, d;
      v = 0;
      p = 1;
      for (int i = 0; i < ndig; i++) begin
         d = int'(raw[4*i +: 4]);
         if (d > 9) d = 9;
         v = v + d * p;
         p = p * 10;
      end
      return (v > mxv) ? mxv : v;
   endfunction

   function automatic logic [15:0] obs_count(input int k);
      case (k)
         0:       return {4'h0, c0};
         1:       return {4'h0, cw};
         default: return c4;
      endcase
   endfunction

   function automatic logic [15:0] obs_lap(input int k);
      case (k)
         0:       return {4'h0, l0};
         1:       return {4'h0, lw};
         default: return l4;
      endcase
   endfunction

   function automatic logic obs_wrap(input int k);
      case (k)
         0:       return w0;
         1:       return ww;
         default: return w4;
      endcase
   endfunction

   // Advance one clock edge and move the reference model along with it.
   task automatic clk_step();
      int st;
      @(posedge clk);
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            mc[k] = 0;
            ml[k] = 0;
            mw[k] = 1'b0;
         end
         mst = 1;
      end else begin
         st = mst;
         for (int k = 0; k < 3; k++) begin
            mw[k] = 1'b0;
            if (lap) ml[k] = mc[k];
            if (clear) begin
               mc[k] = 0;
            end else if (load) begin
               mc[k] = sanitize(load_val, nd[k], mx[k]);
            end else if (st == 1 && tick_en) begin
               if (!dir) begin
                  if (mc[k] == mx[k]) begin mc[k] = 0; mw[k] = 1'b1; end
                  else mc[k] = mc[k] + 1;
               end else begin
                  if (mc[k] == 0) begin mc[k] = mx[k]; mw[k] = 1'b1; end
                  else mc[k] = mc[k] - 1;
               end
            end
         end
         if (clear) mst = 0;
         else if (st == 1 && stop) mst = 2;
         else if (st != 1 && start && !stop) mst = 1;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clk_step();
      clk_step();
      reset = 1'b0;
      nvec++; if (c0 !== 12'h000) begin nerr++; $display("FAIL reset_count got %h want 000", c0); end
      nvec++; if (w0 !== 1'b0) begin nerr++; $display("FAIL reset_wrap got %b want 0", w0); end
      nvec++; if (l0 !== 12'h000) begin nerr++; $display("FAIL reset_lap got %h want 000", l0); end
      nvec++; if (r0 !== 1'b1) begin nerr++; $display("FAIL reset_running got %b want 1", r0); end
      nvec++; if (c4 !== 16'h0000) begin nerr++; $display("FAIL reset_count4 got %h want 0000", c4); end
   endtask

   task automatic test_up_wrap();
      int pulses;
      pulses  = 0;
      tick_en = 1'b1;
      dir     = 1'b0;
      for (int i = 1; i <= 1000; i++) begin
         clk_step();
         if (w0 === 1'b1) pulses++;
         if (i == 998) begin
            nvec++; if (c0 !== 12'h998) begin nerr++; $display("FAIL up_998 got %h want 998", c0); end
         end
         if (i == 999) begin
            nvec++; if (c0 !== 12'h999 || w0 !== 1'b0) begin nerr++; $display("FAIL up_999 got %h/%b want 999/0", c0, w0); end
         end
         if (i == 1000) begin
            nvec++; if (c0 !== 12'h000 || w0 !== 1'b1) begin nerr++; $display("FAIL up_wrap got %h/%b want 000/1", c0, w0); end
         end
         nvec++; if (cw !== to_bcd(mc[1])) begin nerr++; $display("FAIL up_cnt059 got %h want %h", cw, to_bcd(mc[1])); end
         nvec++; if (ww !== mw[1]) begin nerr++; $display("FAIL up_wrap059 got %b want %b", ww, mw[1]); end
      end
      tick_en = 1'b0;
      clk_step();
      nvec++; if (w0 !== 1'b0) begin nerr++; $display("FAIL up_nosticky got %b want 0", w0); end
      nvec++; if (pulses != 1) begin nerr++; $display("FAIL up_pulses got %0d want 1", pulses); end
   endtask

   task automatic test_down();
      dir     = 1'b1;
      tick_en = 1'b1;
      clk_step();
      nvec++; if (c0 !== 12'h999 || w0 !== 1'b1) begin nerr++; $display("FAIL down_wrap got %h/%b want 999/1", c0, w0); end
      clk_step();
      nvec++; if (c0 !== 12'h998 || w0 !== 1'b0) begin nerr++; $display("FAIL down_step got %h/%b want 998/0", c0, w0); end
      tick_en = 1'b0;
      dir     = 1'b0;
   endtask

   task automatic test_small_wrap();
      load = 1'b1; load_val = 16'h0058;
      clk_step();
      load = 1'b0;
      nvec++; if (cw !== 12'h058) begin nerr++; $display("FAIL sw_load got %h want 058", cw); end
      tick_en = 1'b1;
      clk_step();
      nvec++; if (cw !== 12'h059 || ww !== 1'b0) begin nerr++; $display("FAIL sw_top got %h/%b want 059/0", cw, ww); end
      clk_step();
      nvec++; if (cw !== 12'h000 || ww !== 1'b1) begin nerr++; $display("FAIL sw_wrap got %h/%b want 000/1", cw, ww); end
      nvec++; if (c0 !== 12'h060 || w0 !== 1'b0) begin nerr++; $display("FAIL sw_dflt got %h/%b want 060/0", c0, w0); end
      tick_en = 1'b0;
      load = 1'b1; load_val = 16'h00A7;
      clk_step();
      load = 1'b0;
      nvec++; if (cw !== 12'h059 || ww !== 1'b0) begin nerr++; $display("FAIL sw_clamp got %h/%b want 059/0", cw, ww); end
      nvec++; if (c0 !== 12'h097) begin nerr++; $display("FAIL sw_nibble got %h want 097", c0); end
   endtask

   task automatic test_pause();
      load = 1'b1; load_val = 16'h0123;
      clk_step();
      load = 1'b0;
      stop = 1'b1;
      clk_step();
      stop = 1'b0;
      nvec++; if (r0 !== 1'b0) begin nerr++; $display("FAIL pause_running got %b want 0", r0); end
      tick_en = 1'b1;
      repeat (5) clk_step();
      tick_en = 1'b0;
      nvec++; if (c0 !== 12'h123) begin nerr++; $display("FAIL pause_hold got %h want 123", c0); end
      start = 1'b1;
      clk_step();
      start = 1'b0;
      nvec++; if (r0 !== 1'b1) begin nerr++; $display("FAIL pause_resume got %b want 1", r0); end
      tick_en = 1'b1;
      clk_step();
      tick_en = 1'b0;
      nvec++; if (c0 !== 12'h124) begin nerr++; $display("FAIL pause_tick got %h want 124", c0); end
      start = 1'b1; stop = 1'b1;
      clk_step();
      start = 1'b0; stop = 1'b0;
      nvec++; if (r0 !== 1'b0) begin nerr++; $display("FAIL startstop got %b want 0", r0); end
   endtask

   task automatic test_load_lap();
      start = 1'b1;
      clk_step();
      start = 1'b0;
      load = 1'b1; load_val = 16'h0400; tick_en = 1'b1;
      clk_step();
      load = 1'b0;
      nvec++; if (c0 !== 12'h400) begin nerr++; $display("FAIL load_tick got %h want 400", c0); end
      lap = 1'b1;
      clk_step();
      lap = 1'b0; tick_en = 1'b0;
      nvec++; if (l0 !== 12'h400 || c0 !== 12'h401) begin nerr++; $display("FAIL lap_tick got %h/%h want 400/401", l0, c0); end
      lap = 1'b1; clear = 1'b1;
      clk_step();
      lap = 1'b0; clear = 1'b0;
      nvec++; if (l0 !== 12'h401 || c0 !== 12'h000 || r0 !== 1'b0) begin
         nerr++; $display("FAIL lap_clear got %h/%h/%b want 401/000/0", l0, c0, r0);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      clk_step();
      start = 1'b0;
      load = 1'b1; load_val = 16'h0777;
      clk_step();
      load = 1'b0;
      lap = 1'b1;
      clk_step();
      lap = 1'b0;
      nvec++; if (l0 !== 12'h777) begin nerr++; $display("FAIL mid_lap got %h want 777", l0); end
      reset = 1'b1; tick_en = 1'b1;
      clk_step();
      reset = 1'b0; tick_en = 1'b0;
      nvec++; if (c0 !== 12'h000 || w0 !== 1'b0 || l0 !== 12'h000 || r0 !== 1'b1) begin
         nerr++; $display("FAIL mid_reset got %h/%b/%h/%b want 000/0/000/1", c0, w0, l0, r0);
      end
      load = 1'b1; load_val = 16'h9998;
      clk_step();
      load = 1'b0;
      nvec++; if (c4 !== 16'h9998) begin nerr++; $display("FAIL n4_load got %h want 9998", c4); end
      tick_en = 1'b1;
      clk_step();
      nvec++; if (c4 !== 16'h9999 || w4 !== 1'b0) begin nerr++; $display("FAIL n4_top got %h/%b want 9999/0", c4, w4); end
      clk_step();
      nvec++; if (c4 !== 16'h0000 || w4 !== 1'b1) begin nerr++; $display("FAIL n4_wrap got %h/%b want 0000/1", c4, w4); end
      tick_en = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         reset    = ($urandom_range(0, 99) == 0);
         clear    = ($urandom_range(0, 99) < 3);
         load     = ($urandom_range(0, 99) < 6);
         start    = ($urandom_range(0, 99) < 12);
         stop     = ($urandom_range(0, 99) < 5);
         lap      = ($urandom_range(0, 99) < 10);
         tick_en  = ($urandom_range(0, 99) < 75);
         dir      = ($urandom_range(0, 3) == 0);
         load_val = 16'($urandom);
         clk_step();
         for (int k = 0; k < 3; k++) begin
            nvec++; if (obs_count(k) !== to_bcd(mc[k])) begin nerr++; $display("FAIL rnd_count%0d got %h want %h", k, obs_count(k), to_bcd(mc[k])); end
            nvec++; if (obs_wrap(k) !== mw[k]) begin nerr++; $display("FAIL rnd_wrap%0d got %b want %b", k, obs_wrap(k), mw[k]); end
            nvec++; if (obs_lap(k) !== to_bcd(ml[k])) begin nerr++; $display("FAIL rnd_lap%0d got %h want %h", k, obs_lap(k), to_bcd(ml[k])); end
         end
         nvec++; if (r4 !== (mst == 1)) begin nerr++; $display("FAIL rnd_running got %b want %b", r4, (mst == 1)); end
      end
      reset = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0;
      stop = 1'b0; lap = 1'b0; tick_en = 1'b0; dir = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tick_en = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
      dir = 1'b0; load = 1'b0; lap = 1'b0; load_val = '0;
      mst = 1;
      for (int k = 0; k < 3; k++) begin
         mc[k] = 0; ml[k] = 0; mw[k] = 1'b0;
      end
      test_reset();
      test_up_wrap();
      test_down();
      test_small_wrap();
      test_pause();
      test_load_lap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
